// File: rtl/turn_sequencer.sv
// turn_sequencer: play-phase controller for the 5x5 battleship game.
// Alternates player and environment turns, counts down the player's turn
// in seconds, and ends the game on victory or defeat. Every output is a
// register.
module turn_sequencer #(
    parameter int unsigned TURN_SECS = 10,         // player turn length, 1..15
    parameter int unsigned TICK_DIV  = 50_000_000  // clk cycles per second, >= 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       p_done,
    input  logic       e_done,
    input  logic       enemy_all_sunk,
    input  logic       player_all_sunk,
    output logic       p_turn,
    output logic       e_turn,
    output logic       timeout,
    output logic [3:0] secs_left,
    output logic [7:0] rounds,
    output logic [1:0] game_state
);

    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [3:0] SECS_INIT = 4'(TURN_SECS);

    localparam logic [1:0] GS_PLAYING = 2'b00;
    localparam logic [1:0] GS_VICTORY = 2'b10;
    localparam logic [1:0] GS_DEFEAT  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        P_TURN,
        P_CHECK,
        E_TURN,
        E_CHECK,
        DONE
    } state_t;

    state_t            state;
    logic [TICK_W-1:0] tick;

    // Turn sequencing, per-second countdown and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tick       <= '0;
            p_turn     <= 1'b0;
            e_turn     <= 1'b0;
            timeout    <= 1'b0;
            secs_left  <= '0;
            rounds     <= '0;
            game_state <= GS_PLAYING;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= P_TURN;
                        p_turn    <= 1'b1;
                        secs_left <= SECS_INIT;
                        tick      <= '0;
                    end
                end
                P_TURN: begin
                    // A committed shot beats a coincident final tick wrap.
                    if (p_done) begin
                        state  <= P_CHECK;
                        p_turn <= 1'b0;
                    end else if (tick == TICK_LAST) begin
                        tick <= '0;
                        if (secs_left == 4'd1) begin
                            // Forfeit: hand over without evaluating the enemy board.
                            secs_left <= '0;
                            timeout   <= 1'b1;
                            p_turn    <= 1'b0;
                            e_turn    <= 1'b1;
                            state     <= E_TURN;
                        end else begin
                            secs_left <= secs_left - 4'd1;
                        end
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                P_CHECK: begin
                    if (enemy_all_sunk) begin
                        game_state <= GS_VICTORY;
                        state      <= DONE;
                    end else begin
                        e_turn <= 1'b1;
                        state  <= E_TURN;
                    end
                end
                E_TURN: begin
                    if (e_done) begin
                        e_turn <= 1'b0;
                        state  <= E_CHECK;
                    end
                end
                E_CHECK: begin
                    if (player_all_sunk) begin
                        game_state <= GS_DEFEAT;
                        state      <= DONE;
                    end else begin
                        if (rounds != 8'hFF) begin
                            rounds <= rounds + 8'd1;
                        end
                        p_turn    <= 1'b1;
                        secs_left <= SECS_INIT;
                        tick      <= '0;
                        state     <= P_TURN;
                    end
                end
                DONE: begin
                    p_turn <= 1'b0;
                    e_turn <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: directed scenarios plus random stimulus, compared each
// cycle against a behavioural model that tracks elapsed player-turn time.
module tb_turn_sequencer;

    localparam int TS = 3;
    localparam int TD = 4;

    // Model phase identifiers.
    localparam int PH_IDLE   = 0;
    localparam int PH_PLAYER = 1;
    localparam int PH_PCHK   = 2;
    localparam int PH_ENV    = 3;
    localparam int PH_ECHK   = 4;
    localparam int PH_OVER   = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       p_done;
    logic       e_done;
    logic       enemy_all_sunk;
    logic       player_all_sunk;
    logic       p_turn;
    logic       e_turn;
    logic       timeout;
    logic [3:0] secs_left;
    logic [7:0] rounds;
    logic [1:0] game_state;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    turn_sequencer #(
        .TURN_SECS (TS),
        .TICK_DIV  (TD)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .p_done          (p_done),
        .e_done          (e_done),
        .enemy_all_sunk  (enemy_all_sunk),
        .player_all_sunk (player_all_sunk),
        .p_turn          (p_turn),
        .e_turn          (e_turn),
        .timeout         (timeout),
        .secs_left       (secs_left),
        .rounds          (rounds),
        .game_state      (game_state)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase plus cycles elapsed in the current player turn.
    int m_phase   = PH_IDLE;
    int m_elapsed = TS * TD;
    int m_rounds  = 0;
    int m_gs      = 0;
    int m_timeout = 0;

    function automatic int exp_secs();
        return TS - (m_elapsed / TD);
    endfunction

    always @(posedge clk) begin
        m_timeout = 0;
        if (rst) begin
            m_phase   = PH_IDLE;
            m_elapsed = TS * TD;
            m_rounds  = 0;
            m_gs      = 0;
        end else begin
            case (m_phase)
                PH_IDLE: if (start) begin
                    m_phase   = PH_PLAYER;
                    m_elapsed = 0;
                end
                PH_PLAYER: begin
                    if (p_done) begin
                        m_phase = PH_PCHK;
                    end else begin
                        m_elapsed = m_elapsed + 1;
                        if (m_elapsed == TS * TD) begin
                            m_timeout = 1;
                            m_phase   = PH_ENV;
                        end
                    end
                end
                PH_PCHK: begin
                    if (enemy_all_sunk) begin
                        m_gs    = 2;
                        m_phase = PH_OVER;
                    end else begin
                        m_phase = PH_ENV;
                    end
                end
                PH_ENV: if (e_done) m_phase = PH_ECHK;
                PH_ECHK: begin
                    if (player_all_sunk) begin
                        m_gs    = 3;
                        m_phase = PH_OVER;
                    end else begin
                        if (m_rounds < 255) m_rounds = m_rounds + 1;
                        m_elapsed = 0;
                        m_phase   = PH_PLAYER;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("p_turn",     int'(p_turn),     int'(m_phase == PH_PLAYER));
            check("e_turn",     int'(e_turn),     int'(m_phase == PH_ENV));
            check("timeout",    int'(timeout),    m_timeout);
            check("secs_left",  int'(secs_left),  exp_secs());
            check("rounds",     int'(rounds),     m_rounds);
            check("game_state", int'(game_state), m_gs);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic toggle_junk(input int n);
        repeat (n) begin
            p_done = 1'($urandom_range(0, 1));
            e_done = 1'($urandom_range(0, 1));
            start  = 1'($urandom_range(0, 1));
            cycles(1);
        end
        p_done = 1'b0;
        e_done = 1'b0;
        start  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; p_done = 1'b0; e_done = 1'b0;
        enemy_all_sunk = 1'b0; player_all_sunk = 1'b0;
        cycles(1);
        chk_en = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("rst_p_turn", int'(p_turn), 0);
        check("rst_secs", int'(secs_left), 0);
        check("rst_rounds", int'(rounds), 0);
        check("rst_gs", int'(game_state), 0);
        cycles(3);

        // Start, countdown, timeout.
        start = 1'b1; cycles(1); start = 1'b0;
        check("start_p_turn", int'(p_turn), 1);
        check("start_secs", int'(secs_left), 3);
        check("model_start_secs", exp_secs(), 3);
        cycles(4);
        check("secs_after_4", int'(secs_left), 2);
        check("model_secs_after_4", exp_secs(), 2);
        check("gs_playing", int'(game_state), 0);
        cycles(8);
        check("to_pulse", int'(timeout), 1);
        check("to_secs", int'(secs_left), 0);
        check("to_e_turn", int'(e_turn), 1);
        check("to_p_turn", int'(p_turn), 0);
        check("to_rounds", int'(rounds), 0);
        cycles(1);
        check("to_single", int'(timeout), 0);
        check("to_e_turn_hold", int'(e_turn), 1);

        // Complete the round.
        e_done = 1'b1; cycles(1); e_done = 1'b0;
        check("echk_e_turn", int'(e_turn), 0);
        cycles(1);
        check("round1_p_turn", int'(p_turn), 1);
        check("round1_rounds", int'(rounds), 1);
        check("round1_secs", int'(secs_left), 3);

        // p_done on the final tick wrap beats timeout.
        cycles(11);
        p_done = 1'b1; cycles(1); p_done = 1'b0;
        check("race_p_turn", int'(p_turn), 0);
        check("race_timeout", int'(timeout), 0);
        check("race_secs", int'(secs_left), 1);
        cycles(1);
        check("race_e_turn", int'(e_turn), 1);
        check("race_gs", int'(game_state), 0);

        // Defeat.
        player_all_sunk = 1'b1;
        e_done = 1'b1; cycles(1); e_done = 1'b0;
        cycles(1);
        check("defeat_gs", int'(game_state), 3);
        check("defeat_rounds", int'(rounds), 1);
        toggle_junk(24);
        check("defeat_hold_gs", int'(game_state), 3);
        check("defeat_hold_p", int'(p_turn), 0);
        check("defeat_hold_e", int'(e_turn), 0);

        // Reset out of DONE.
        rst = 1'b1; cycles(1); rst = 1'b0;
        check("rstdone_gs", int'(game_state), 0);
        check("rstdone_rounds", int'(rounds), 0);
        check("rstdone_secs", int'(secs_left), 0);
        player_all_sunk = 1'b0;

        // Victory: level already high before start does not end the game early.
        enemy_all_sunk = 1'b1;
        start = 1'b1; cycles(1); start = 1'b0;
        check("win_p_turn", int'(p_turn), 1);
        check("win_gs_early", int'(game_state), 0);
        cycles(4);
        p_done = 1'b1; cycles(1); p_done = 1'b0;
        check("win_pchk_p_turn", int'(p_turn), 0);
        cycles(1);
        check("win_gs", int'(game_state), 2);
        toggle_junk(24);
        check("win_hold_gs", int'(game_state), 2);
        check("win_hold_e", int'(e_turn), 0);
        rst = 1'b1; cycles(1); rst = 1'b0;
        enemy_all_sunk = 1'b0;

        // Reset mid environment turn.
        start = 1'b1; cycles(1); start = 1'b0;
        p_done = 1'b1; cycles(1); p_done = 1'b0;
        cycles(1);
        check("mid_e_turn", int'(e_turn), 1);
        cycles(3);
        rst = 1'b1; cycles(1); rst = 1'b0;
        check("mid_rst_e_turn", int'(e_turn), 0);
        check("mid_rst_secs", int'(secs_left), 0);
        check("mid_rst_gs", int'(game_state), 0);
        start = 1'b1; cycles(1); start = 1'b0;
        check("fresh_p_turn", int'(p_turn), 1);
        check("fresh_rounds", int'(rounds), 0);

        // Random phase.
        for (int i = 0; i < 4000; i++) begin
            rst             = ($urandom_range(0, 299) == 0);
            start           = ($urandom_range(0, 7) == 0);
            p_done          = ($urandom_range(0, 13) == 0);
            e_done          = ($urandom_range(0, 5) == 0);
            enemy_all_sunk  = ($urandom_range(0, 7) == 0);
            player_all_sunk = ($urandom_range(0, 7) == 0);
            cycles(1);
        end
        rst = 1'b0; start = 1'b0; p_done = 1'b0; e_done = 1'b0;
        cycles(2);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Controller that sequences the play phase of the 5x5 battleship game once ship placement is complete.
- Alternates player and environment turns and runs a per-turn countdown for the player. A player turn that times out is forfeited.
- Evaluates win/loss after every turn and drives the final game_state.
- Sits between the top-level game FSM and the player-play unit, environment-play unit, win/lose checkers and the timer display converter.

Parameters:
- TURN_SECS, 10, player turn length in seconds. Legal range 1..15.
- TICK_DIV, 50_000_000, clk cycles per second. Must be >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: placement finished, begin play
- p_done  in  1  one-cycle pulse from player-play unit: shot committed
- e_done  in  1  one-cycle pulse from environment-play unit: shot committed
- enemy_all_sunk  in  1  level from win checker on enemy board
- player_all_sunk  in  1  level from loss checker on player board
- p_turn  out  1  enable to player-play unit
- e_turn  out  1  enable to environment-play unit
- timeout  out  1  one-cycle pulse: player turn forfeited
- secs_left  out  4  remaining seconds of current player turn (to display converter)
- rounds  out  8  completed full rounds, saturating
- game_state  out  2  00 playing, 10 victory, 11 defeat

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; p_turn=0, e_turn=0, timeout=0, secs_left=0, rounds=0, game_state=00; internal tick counter=0.
- rst is sampled every cycle and overrides everything, including mid-turn and DONE.
- States: IDLE, P_TURN, P_CHECK, E_TURN, E_CHECK, DONE.
- IDLE:
  - On start=1, go to P_TURN. On entry, secs_left=TURN_SECS and tick=0.
  - p_turn=1 in the cycle after start is sampled (latency 1).
  - start is ignored in all other states.
- P_TURN:
  - p_turn=1.
  - tick increments each cycle. At tick==TICK_DIV-1, tick wraps to 0 and secs_left decrements.
  - On p_done=1, go to P_CHECK. secs_left freezes at its current value.
  - Timeout: tick wraps while secs_left==1. Then secs_left becomes 0, timeout pulses for 1 cycle, and the FSM goes directly to E_TURN without a check.
  - If p_done and timeout coincide in the same cycle, p_done wins: go to P_CHECK, no timeout pulse.
- P_CHECK (1 cycle):
  - p_turn=0.
  - If enemy_all_sunk=1, game_state=10 and go to DONE. Otherwise go to E_TURN.
- E_TURN:
  - e_turn=1 until e_done=1, then go to E_CHECK.
  - No time limit. secs_left holds.
- E_CHECK (1 cycle):
  - e_turn=0.
  - If player_all_sunk=1, game_state=11 and go to DONE.
  - Otherwise rounds increments (holds at 255) and go to P_TURN. secs_left reloads to TURN_SECS and tick clears.
- DONE:
  - All enables are 0 and game_state holds.
  - Exit only via rst.
- Stray pulses: p_done outside P_TURN and e_done outside E_TURN are ignored. p_turn and e_turn are never both 1.
- Check levels: enemy_all_sunk and player_all_sunk are sampled only in their check state. Levels already high at start do not end the game before the first check.
- Loss check: player_all_sunk is never evaluated after a player turn, and enemy_all_sunk is never evaluated after a timeout.

Test Plan (TICK_DIV=4, TURN_SECS=3):
- Reset, then start pulse -> next cycle p_turn=1, secs_left=3. After 4 cycles secs_left=2. game_state=00.
- In P_TURN, no p_done for 12 cycles -> secs_left=0, a single timeout pulse, e_turn=1 the next cycle, rounds=0.
- p_done on cycle 5 of P_TURN with enemy_all_sunk=1 -> p_turn drops, one P_CHECK cycle, game_state=10, enables stay 0 for 20+ cycles while p_done/e_done/start are toggled.
- Full round: p_done, enemy_all_sunk=0, e_done, player_all_sunk=0 -> rounds=1, p_turn=1, secs_left reloaded to 3. Second e_done with player_all_sunk=1 -> game_state=11.
- p_done asserted on the same cycle as the final tick wrap (secs_left==1) -> P_CHECK taken, timeout stays 0.
- rst asserted mid E_TURN, and separately in DONE -> all outputs return to reset values the next cycle. A following start begins a fresh game with rounds=0.
